ram_sp_param: RTL and testbench

//   Parametrised synchronous single-port RAM. Successor to the fixed 512x16 RAM.

---
 rtl/ram_sp_param.sv | 105 ++++++++++
 tb/tb_ram_sp_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with per-byte write enables, registered read,
// selectable read-during-write behaviour, range checking and a post-reset clear sequencer.
module ram_sp_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int READ_MODE  = 0,
  parameter int CLEAR_INIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  w,
  input  logic                  r,
  input  logic [ADDR_W-1:0]     add,
  input  logic [DATA_W-1:0]     d_in,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     d_out,
  output logic                  rd_vld,
  output logic                  busy,
  output logic                  err
);

  localparam int                NB       = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              req;
  logic              do_write;
  logic              do_read;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;

  // Extra top bit keeps the comparison exact even when DEPTH == 2**ADDR_W.
  assign in_range = ({1'b0, add} < (ADDR_W + 1)'(DEPTH));
  assign req      = (state == ST_RUN) && en && (r || w);
  assign do_write = req && in_range && w;
  assign do_read  = req && in_range && r;
  assign busy     = (state == ST_CLEAR);
  assign old_word = in_range ? mem[add] : '0;

  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) merged_word[8*k +: 8] = d_in[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_RUN;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      ST_CLEAR: begin
        if (ptr == LAST_PTR) begin
          state_next = ST_RUN;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + ADDR_W'(1);
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // The array has no reset; it is only ever zeroed by the clear sequencer.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (do_write) begin
      mem[add] <= merged_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out  <= '0;
      rd_vld <= 1'b0;
      err    <= 1'b0;
    end else begin
      rd_vld <= do_read;
      err    <= req && !in_range;
      if (do_read) begin
        d_out <= ((READ_MODE != 0) && w) ? merged_word : old_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// Randomised bench for ram_sp_param: two instances (512 words read-first with clear,
// 300 words write-first without clear) share stimulus and are checked against a word-array model.
module tb_ram_sp_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, w, r;
  logic [8:0]  add;
  logic [15:0] d_in;
  logic [1:0]  be;

  logic [15:0] dout_a, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b, err_a, err_b;

  int checks = 0;
  int errors = 0;
  bit checking_on = 1'b0;
  int cnt;

  logic [15:0] m_mem  [2][512];
  bit   [15:0] m_kn   [2][512];
  logic [15:0] m_dout [2];
  bit   [15:0] m_dkn  [2];
  bit          m_vld  [2];
  bit          m_err  [2];
  int          m_left [2];

  always #5 clk = ~clk;

  ram_sp_param #(.DATA_W(16), .ADDR_W(9), .DEPTH(512), .READ_MODE(0), .CLEAR_INIT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .w(w), .r(r), .add(add), .d_in(d_in), .be(be),
    .d_out(dout_a), .rd_vld(vld_a), .busy(busy_a), .err(err_a)
  );

  ram_sp_param #(.DATA_W(16), .ADDR_W(9), .DEPTH(300), .READ_MODE(1), .CLEAR_INIT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .w(w), .r(r), .add(add), .d_in(d_in), .be(be),
    .d_out(dout_b), .rd_vld(vld_b), .busy(busy_b), .err(err_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instance 0 = 512 words, read-first, cleared; instance 1 = 300 words, write-first, uncleared.
  function automatic void modelStep(input int i, input bit in_reset);
    int          dep;
    bit          wf;
    logic [15:0] old_w, new_w;
    bit   [15:0] old_k, new_k;
    dep = (i == 0) ? 512 : 300;
    wf  = (i == 1);
    if (in_reset) begin
      m_dout[i] = '0;
      m_dkn[i]  = '1;
      m_vld[i]  = 1'b0;
      m_err[i]  = 1'b0;
      m_left[i] = (i == 0) ? dep : 0;
      return;
    end
    m_vld[i] = 1'b0;
    m_err[i] = 1'b0;
    if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        for (int j = 0; j < dep; j++) begin
          m_mem[i][j] = '0;
          m_kn[i][j]  = '1;
        end
      end
      return;
    end
    if (en && (r || w)) begin
      if (int'(add) >= dep) begin
        m_err[i] = 1'b1;
      end else begin
        old_w = m_mem[i][add];
        old_k = m_kn[i][add];
        new_w = old_w;
        new_k = old_k;
        for (int k = 0; k < 2; k++) begin
          if (be[k]) begin
            new_w[8*k +: 8] = d_in[8*k +: 8];
            new_k[8*k +: 8] = 8'hFF;
          end
        end
        if (w) begin
          m_mem[i][add] = new_w;
          m_kn[i][add]  = new_k;
        end
        if (r) begin
          m_vld[i]  = 1'b1;
          m_dout[i] = (wf && w) ? new_w : old_w;
          m_dkn[i]  = (wf && w) ? new_k : old_k;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) modelStep(i, !rst_n);
  end

  task automatic compareInst(input int i, input logic [15:0] dout, input logic vld,
                             input logic bsy, input logic er);
    string sfx;
    sfx = (i == 0) ? "a" : "b";
    checkOutput({"busy_", sfx}, 32'(bsy), 32'(m_left[i] > 0));
    checkOutput({"rd_vld_", sfx}, 32'(vld), 32'(m_vld[i]));
    checkOutput({"err_", sfx}, 32'(er), 32'(m_err[i]));
    if (m_dkn[i] != 16'h0000) begin
      checkOutput({"d_out_", sfx}, 32'(dout & m_dkn[i]), 32'(m_dout[i] & m_dkn[i]));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (checking_on) begin
      compareInst(0, dout_a, vld_a, busy_a, err_a);
      compareInst(1, dout_b, vld_b, busy_b, err_b);
    end
  end

  task automatic applyStimulus(input bit e, input bit ww, input bit rr, input logic [8:0] a,
                               input logic [15:0] dd, input logic [1:0] bb);
    en   = e;
    w    = ww;
    r    = rr;
    add  = a;
    d_in = dd;
    be   = bb;
    @(negedge clk);
  endtask

  task automatic randomStep();
    applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  9'($urandom_range(0, 511)), 16'($urandom), 2'($urandom));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 16'd0, 2'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b0; w = 1'b0; r = 1'b0; add = '0; d_in = '0; be = '0;
    #3 rst_n = 1'b0;
    checking_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear length, with random traffic that only the uncleared instance may act on
    cnt = 0;
    do begin
      randomStep();
      cnt++;
    end while (busy_a && cnt < 600);
    checkOutput("clear_cycles", 32'(cnt), 32'd512);

    applyStimulus(1'b1, 1'b0, 1'b1, 9'd300, 16'd0, 2'd0);
    checkOutput("t1_dout_a", 32'(dout_a), 32'h0);
    checkOutput("t1_vld_a", 32'(vld_a), 32'd1);
    checkOutput("t1_err_b", 32'(err_b), 32'd1);

    for (int i = 2; i <= 450; i += 64) applyStimulus(1'b1, 1'b1, 1'b0, 9'(i), 16'(i), 2'b11);
    for (int i = 2; i <= 450; i += 64) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 9'(i), 16'd0, 2'b00);
      checkOutput("t2_dout_a", 32'(dout_a), 32'(i));
      checkOutput("t2_vld_a", 32'(vld_a), 32'd1);
    end
    idle();
    checkOutput("t2_vld_drop", 32'(vld_a), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 9'd5, 16'hAAAA, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b0, 9'd5, 16'h1234, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'd5, 16'h0000, 2'b00);
    checkOutput("t3_dout_a", 32'(dout_a), 32'hAA34);
    checkOutput("t3_dout_b", 32'(dout_b), 32'hAA34);

    applyStimulus(1'b1, 1'b1, 1'b0, 9'd7, 16'h0F0F, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b1, 9'd7, 16'hFFFF, 2'b11);
    checkOutput("t4_rdw_a", 32'(dout_a), 32'h0F0F);
    checkOutput("t4_rdw_b", 32'(dout_b), 32'hFFFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'd7, 16'h0000, 2'b00);
    checkOutput("t4_after_a", 32'(dout_a), 32'hFFFF);
    checkOutput("t4_after_b", 32'(dout_b), 32'hFFFF);

    applyStimulus(1'b1, 1'b1, 1'b0, 9'd400, 16'h5555, 2'b11);
    checkOutput("t5_err_b", 32'(err_b), 32'd1);
    checkOutput("t5_vld_b", 32'(vld_b), 32'd0);
    checkOutput("t5_err_a", 32'(err_a), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'd400, 16'h0000, 2'b00);
    checkOutput("t5_hold_b", 32'(dout_b), 32'hFFFF);
    checkOutput("t5_rderr_b", 32'(err_b), 32'd1);
    checkOutput("t5_dout_a", 32'(dout_a), 32'h5555);
    applyStimulus(1'b0, 1'b1, 1'b1, 9'd2, 16'hDEAD, 2'b11);
    checkOutput("t5_en0_vld", 32'(vld_a), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'd2, 16'h0000, 2'b00);
    checkOutput("t5_en0_a", 32'(dout_a), 32'd2);
    checkOutput("t5_en0_b", 32'(dout_b), 32'd2);

    repeat (3000) randomStep();

    applyStimulus(1'b1, 1'b1, 1'b0, 9'd2, 16'd2, 2'b11);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'd2, 16'd0, 2'b00);
    idle();

    // Asynchronous reset from RUN, then again partway through the clear
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_dout_a", 32'(dout_a), 32'h0);
    checkOutput("t6_dout_b", 32'(dout_b), 32'h0);
    checkOutput("t6_busy_a", 32'(busy_a), 32'd1);
    checkOutput("t6_busy_b", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) idle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_mid_busy_a", 32'(busy_a), 32'd1);
    checkOutput("t6_mid_vld_a", 32'(vld_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    do begin
      idle();
      cnt++;
    end while (busy_a && cnt < 600);
    checkOutput("t6_clear_cycles", 32'(cnt), 32'd512);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'd2, 16'd0, 2'b00);
    checkOutput("t6_keep_b", 32'(dout_b), 32'd2);
    checkOutput("t6_vld_b", 32'(vld_b), 32'd1);
    checkOutput("t6_cleared_a", 32'(dout_a), 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
